// File: rtl/flit_enq_router.sv
// flit_enq_router: steers a flit stream into one of NUM_DEST destination FIFOs.
// It locks the route on each head flit, applies per-FIFO backpressure and counts protocol errors.
`default_nettype none

module flit_enq_router #(
   parameter int FLIT_W   = 16,
   parameter int CTRL_W   = 2,
   parameter int NUM_DEST = 4,
   parameter int DEST_W   = 2,
   parameter int ERR_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [FLIT_W-1:0]   flit_in,
   input  logic [CTRL_W-1:0]   ctrl_in,
   input  logic                valid_in,
   input  logic [DEST_W-1:0]   dest_sel,
   output logic                ready_in,
   input  logic [NUM_DEST-1:0] full_in,
   output logic [FLIT_W-1:0]   flit_out,
   output logic [CTRL_W-1:0]   ctrl_out,
   output logic [NUM_DEST-1:0] enq_en,
   output logic                busy,
   output logic                err_pulse,
   output logic [ERR_W-1:0]    err_cnt
);

   localparam logic [CTRL_W-1:0] c_CTRL_SINGLE = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] c_CTRL_HEAD   = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] c_CTRL_TAIL   = CTRL_W'(3);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ROUTE = 2'd1;
   localparam logic [1:0] c_DROP  = 2'd2;

   localparam logic [DEST_W:0] c_NUM_DEST = (DEST_W+1)'(NUM_DEST);

   logic [1:0]          r_state;
   logic [DEST_W-1:0]   r_route;
   logic [NUM_DEST-1:0] r_enq_en;
   logic [FLIT_W-1:0]   r_flit_out;
   logic [CTRL_W-1:0]   r_ctrl_out;
   logic                r_err_pulse;
   logic [ERR_W-1:0]    r_err_cnt;

   logic                w_is_head;
   logic                w_is_single;
   logic                w_is_hs;
   logic                w_is_tail;
   logic                w_dest_bad;
   logic                w_dest_full;
   logic                w_route_full;
   logic                w_ready;
   logic                w_accept;
   logic [1:0]          w_state_nxt;
   logic [DEST_W-1:0]   w_route_nxt;
   logic                w_wr;
   logic [DEST_W-1:0]   w_wr_idx;
   logic                w_err;
   logic [NUM_DEST-1:0] w_onehot;

   always_comb begin
      w_is_head   = (ctrl_in == c_CTRL_HEAD);
      w_is_single = (ctrl_in == c_CTRL_SINGLE);
      w_is_hs     = w_is_head || w_is_single;
      w_is_tail   = (ctrl_in == c_CTRL_TAIL);
      w_dest_bad  = ({1'b0, dest_sel} >= c_NUM_DEST);

      // Out-of-range indices must never select a full bit, so look up by loop.
      w_dest_full  = 1'b0;
      w_route_full = 1'b0;
      for (int i = 0; i < NUM_DEST; i++) begin
         if (dest_sel == i[DEST_W-1:0]) w_dest_full  = full_in[i];
         if (r_route  == i[DEST_W-1:0]) w_route_full = full_in[i];
      end

      // A head/single always starts a new packet, so it uses the idle-state rule.
      if (w_is_hs)                 w_ready = w_dest_bad || !w_dest_full;
      else if (r_state == c_ROUTE) w_ready = !w_route_full;
      else                         w_ready = 1'b1;

      w_accept = valid_in && w_ready;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_route_nxt = r_route;
      w_wr        = 1'b0;
      w_wr_idx    = r_route;
      w_err       = 1'b0;
      if (w_accept) begin
         if (w_is_hs) begin
            w_err = (r_state != c_IDLE) || w_dest_bad;
            if (w_dest_bad) begin
               w_state_nxt = w_is_head ? c_DROP : c_IDLE;
            end else begin
               w_wr        = 1'b1;
               w_wr_idx    = dest_sel;
               w_state_nxt = w_is_head ? c_ROUTE : c_IDLE;
               if (w_is_head) w_route_nxt = dest_sel;
            end
         end else begin
            case (r_state)
               c_IDLE:  w_err = 1'b1;
               c_ROUTE: begin
                  w_wr = 1'b1;
                  if (w_is_tail) w_state_nxt = c_IDLE;
               end
               c_DROP:  if (w_is_tail) w_state_nxt = c_IDLE;
               default: w_state_nxt = c_IDLE;
            endcase
         end
      end

      for (int i = 0; i < NUM_DEST; i++) begin
         w_onehot[i] = w_wr && (w_wr_idx == i[DEST_W-1:0]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= c_IDLE;
         r_route     <= '0;
         r_enq_en    <= '0;
         r_flit_out  <= '0;
         r_ctrl_out  <= '0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_route     <= w_route_nxt;
         r_enq_en    <= w_onehot;
         r_err_pulse <= w_err;
         if (w_accept) begin
            r_flit_out <= flit_in;
            r_ctrl_out <= ctrl_in;
         end
         if (w_err && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign ready_in  = w_ready;
   assign flit_out  = r_flit_out;
   assign ctrl_out  = r_ctrl_out;
   assign enq_en    = r_enq_en;
   assign busy      = (r_state != c_IDLE);
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_flit_enq_router.sv
// tb_flit_enq_router: directed-vector bench for flit_enq_router (4- and 3-destination instances).
`default_nettype none

module tb_flit_enq_router;

   logic        clk;
   logic        rst;

   logic [15:0] a_flit;
   logic [1:0]  a_ctrl;
   logic        a_valid;
   logic [1:0]  a_dest;
   logic        a_ready;
   logic [3:0]  a_full;
   logic [15:0] a_flit_out;
   logic [1:0]  a_ctrl_out;
   logic [3:0]  a_enq;
   logic        a_busy;
   logic        a_errp;
   logic [7:0]  a_errc;

   logic [15:0] b_flit;
   logic [1:0]  b_ctrl;
   logic        b_valid;
   logic [1:0]  b_dest;
   logic        b_ready;
   logic [2:0]  b_full;
   logic [15:0] b_flit_out;
   logic [1:0]  b_ctrl_out;
   logic [2:0]  b_enq;
   logic        b_busy;
   logic        b_errp;
   logic [7:0]  b_errc;

   int n_checks;
   int n_errors;

   flit_enq_router #(.FLIT_W(16), .CTRL_W(2), .NUM_DEST(4), .DEST_W(2), .ERR_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .flit_in(a_flit), .ctrl_in(a_ctrl), .valid_in(a_valid),
      .dest_sel(a_dest), .ready_in(a_ready), .full_in(a_full), .flit_out(a_flit_out),
      .ctrl_out(a_ctrl_out), .enq_en(a_enq), .busy(a_busy), .err_pulse(a_errp), .err_cnt(a_errc)
   );

   flit_enq_router #(.FLIT_W(16), .CTRL_W(2), .NUM_DEST(3), .DEST_W(2), .ERR_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .flit_in(b_flit), .ctrl_in(b_ctrl), .valid_in(b_valid),
      .dest_sel(b_dest), .ready_in(b_ready), .full_in(b_full), .flit_out(b_flit_out),
      .ctrl_out(b_ctrl_out), .enq_en(b_enq), .busy(b_busy), .err_pulse(b_errp), .err_cnt(b_errc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drv_a(input logic v, input logic [1:0] c, input logic [1:0] d, input logic [15:0] f);
      a_valid = v; a_ctrl = c; a_dest = d; a_flit = f;
      @(posedge clk);
      #1;
   endtask

   task automatic drv_b(input logic v, input logic [1:0] c, input logic [1:0] d, input logic [15:0] f);
      b_valid = v; b_ctrl = c; b_dest = d; b_flit = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      a_flit = '0; a_ctrl = '0; a_valid = 1'b0; a_dest = '0; a_full = '0;
      b_flit = '0; b_ctrl = '0; b_valid = 1'b0; b_dest = '0; b_full = '0;
      #1;
      check("rst_enq", a_enq, 4'b0000);
      check("rst_busy", a_busy, 0);
      check("rst_errc", a_errc, 0);
      check("rst_errp", a_errp, 0);
      check("rst_flit", a_flit_out, 0);
      check("rst_ctrl", a_ctrl_out, 0);
      #10 rst = 1'b1;

      // 3-flit packet to dest 2
      drv_a(1, 2'b01, 2'd2, 16'hA001);
      check("p1_head_enq", a_enq, 4'b0100);
      check("p1_head_flit", a_flit_out, 16'hA001);
      check("p1_head_busy", a_busy, 1);
      drv_a(1, 2'b10, 2'd0, 16'hA002);
      check("p1_body_enq", a_enq, 4'b0100);
      check("p1_body_flit", a_flit_out, 16'hA002);
      drv_a(1, 2'b11, 2'd0, 16'hA003);
      check("p1_tail_enq", a_enq, 4'b0100);
      check("p1_tail_ctrl", a_ctrl_out, 2'b11);
      check("p1_tail_busy", a_busy, 0);
      drv_a(0, 2'b10, 2'd0, 16'hFFFF);
      check("idle_enq", a_enq, 4'b0000);
      check("idle_hold", a_flit_out, 16'hA003);

      // back-to-back singles
      drv_a(1, 2'b00, 2'd1, 16'hB001);
      check("s1_enq", a_enq, 4'b0010);
      check("s1_busy", a_busy, 0);
      drv_a(1, 2'b00, 2'd3, 16'hB002);
      check("s2_enq", a_enq, 4'b1000);
      check("s2_flit", a_flit_out, 16'hB002);
      check("s2_busy", a_busy, 0);

      // backpressure on dest 0; full on dest 1 is irrelevant
      a_full = 4'b0010;
      drv_a(1, 2'b01, 2'd0, 16'hC001);
      check("bp_head_enq", a_enq, 4'b0001);
      a_full = 4'b0011;
      a_valid = 1'b1; a_ctrl = 2'b10; a_flit = 16'hC002;
      #1 check("bp_ready0_a", a_ready, 0);
      drv_a(1, 2'b10, 2'd0, 16'hC002);
      check("bp_stall1_enq", a_enq, 4'b0000);
      check("bp_stall1_rdy", a_ready, 0);
      drv_a(1, 2'b10, 2'd0, 16'hC002);
      check("bp_stall2_enq", a_enq, 4'b0000);
      a_full = 4'b0010;
      #1 check("bp_ready1", a_ready, 1);
      drv_a(1, 2'b10, 2'd0, 16'hC002);
      check("bp_body_enq", a_enq, 4'b0001);
      check("bp_body_flit", a_flit_out, 16'hC002);
      drv_a(1, 2'b11, 2'd0, 16'hC003);
      check("bp_tail_enq", a_enq, 4'b0001);
      check("bp_tail_flit", a_flit_out, 16'hC003);
      check("bp_tail_busy", a_busy, 0);
      a_full = 4'b0000;

      // protocol errors: body in idle, head while routing
      drv_a(1, 2'b10, 2'd0, 16'hD000);
      check("e1_enq", a_enq, 4'b0000);
      check("e1_pulse", a_errp, 1);
      check("e1_cnt", a_errc, 1);
      drv_a(1, 2'b01, 2'd2, 16'hD001);
      check("e_head_pulse", a_errp, 0);
      check("e_head_enq", a_enq, 4'b0100);
      drv_a(1, 2'b01, 2'd3, 16'hD002);
      check("e2_pulse", a_errp, 1);
      check("e2_cnt", a_errc, 2);
      check("e2_enq", a_enq, 4'b1000);
      check("e2_busy", a_busy, 1);
      drv_a(1, 2'b11, 2'd0, 16'hD003);
      check("e2_tail_enq", a_enq, 4'b1000);
      check("e2_tail_pulse", a_errp, 0);
      check("e2_tail_busy", a_busy, 0);

      // asynchronous reset mid-packet
      drv_a(1, 2'b01, 2'd1, 16'hE001);
      check("r_head_enq", a_enq, 4'b0010);
      a_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("r_enq", a_enq, 4'b0000);
      check("r_busy", a_busy, 0);
      check("r_errc", a_errc, 0);
      #3 rst = 1'b1;
      drv_a(1, 2'b11, 2'd0, 16'hE002);
      check("r_tail_enq", a_enq, 4'b0000);
      check("r_tail_cnt", a_errc, 1);
      check("r_tail_pulse", a_errp, 1);

      // saturation: 259 errors in total
      for (int i = 0; i < 258; i++) drv_a(1, 2'b10, 2'd0, 16'h5A5A);
      check("sat_cnt", a_errc, 8'd255);
      drv_a(0, 2'b10, 2'd0, 16'h0000);
      check("sat_pulse_end", a_errp, 0);
      check("sat_hold", a_errc, 8'd255);

      // 3-destination instance: invalid destination drops the packet
      b_valid = 1'b1; b_ctrl = 2'b01; b_dest = 2'd3; b_flit = 16'hF001;
      #1 check("d_head_ready", b_ready, 1);
      drv_b(1, 2'b01, 2'd3, 16'hF001);
      check("d_head_enq", b_enq, 3'b000);
      check("d_head_busy", b_busy, 1);
      check("d_head_cnt", b_errc, 1);
      drv_b(1, 2'b10, 2'd0, 16'hF002);
      check("d_body_enq", b_enq, 3'b000);
      check("d_body_cnt", b_errc, 1);
      drv_b(1, 2'b11, 2'd0, 16'hF003);
      check("d_tail_enq", b_enq, 3'b000);
      check("d_tail_busy", b_busy, 0);
      check("d_tail_cnt", b_errc, 1);
      drv_b(1, 2'b01, 2'd1, 16'hF004);
      check("d_next_enq", b_enq, 3'b010);
      check("d_next_flit", b_flit_out, 16'hF004);
      check("d_next_cnt", b_errc, 1);
      drv_b(0, 2'b10, 2'd0, 16'h0000);
      check("d_idle_enq", b_enq, 3'b000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
